// File: rtl/cr16_pkg.sv
// Shared types and constants for the CR16 register-file read-back checker.
// CR16_CHK_ERR_COUNT_EN (optional) adds a saturating mismatch counter.
package cr16_pkg;

    localparam int CR16_REG_SEL_W = 4;
    localparam int CR16_MAX_REGS  = 16;
    localparam int CR16_ERR_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPARE,
        ST_DONE
    } chk_state_t;

    // Mismatch counter stops at 16 so a full 16-register scan fits exactly.
    function automatic logic [CR16_ERR_CNT_W-1:0] err_sat_inc(input logic [CR16_ERR_CNT_W-1:0] c);
        return (c >= CR16_ERR_CNT_W'(CR16_MAX_REGS)) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/cr16_test1_checker_if.sv
// Checker <-> datapath/board bus. master = checker side, slave = datapath/bench side.
// CR16_CHK_ERR_COUNT_EN adds err_count to the bundle.
interface cr16_test1_checker_if #(parameter int DATA_WIDTH = 16);
    import cr16_pkg::*;

    logic                      start;
    logic                      phase;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [CR16_REG_SEL_W-1:0] read_port_sel;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [CR16_REG_SEL_W-1:0] fail_index;
    logic [DATA_WIDTH-1:0]     fail_data;
`ifdef CR16_CHK_ERR_COUNT_EN
    logic [CR16_ERR_CNT_W-1:0] err_count;

    modport master (input start, phase, read_data,
                    output read_port_sel, busy, done, pass, fail_index, fail_data, err_count);
    modport slave  (output start, phase, read_data,
                    input read_port_sel, busy, done, pass, fail_index, fail_data, err_count);
`else
    modport master (input start, phase, read_data,
                    output read_port_sel, busy, done, pass, fail_index, fail_data);
    modport slave  (output start, phase, read_data,
                    input read_port_sel, busy, done, pass, fail_index, fail_data);
`endif

endinterface

// File: rtl/cr16_fib_gen.sv
// Fibonacci expectation generator: holds the pair (e_i, e_i+1), wraps at DATA_WIDTH.
module cr16_fib_gen #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] e
);

    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] nxt;

    // Reload to (1,1) on reset/load, otherwise advance one term per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= DATA_WIDTH'(1);
            nxt <= DATA_WIDTH'(1);
        end else if (load) begin
            cur <= DATA_WIDTH'(1);
            nxt <= DATA_WIDTH'(1);
        end else if (step) begin
            cur <= nxt;
            nxt <= cur + nxt;
        end
    end

    assign e = cur;

endmodule

// File: rtl/cr16_test1_checker.sv
// Read-back checker for the CR16 register-file test program. Scans r0..NUM_REGS-1
// through the read port and compares against Fibonacci (phase 0) or Fibonacci+1 (phase 1).
// Macro CR16_CHK_ERR_COUNT_EN: scan all registers and count mismatches; otherwise
// the scan stops at the first mismatch.
module cr16_test1_checker
    import cr16_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REGS     = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic I_CLK,
    input  logic I_NRESET,
    cr16_test1_checker_if.master bus
);

    chk_state_t                state;
    logic [CR16_REG_SEL_W-1:0] idx;
    logic [1:0]                lat_cnt;
    logic                      phase_q;
    logic                      seen;
    logic [DATA_WIDTH-1:0]     exp_e;
    logic [DATA_WIDTH-1:0]     exp_val;
    logic                      accept;
    logic                      mismatch;
    logic                      last;
    logic                      stop;

    assign accept   = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign exp_val  = phase_q ? exp_e + DATA_WIDTH'(1) : exp_e;
    assign mismatch = (bus.read_data != exp_val);
    assign last     = (idx == CR16_REG_SEL_W'(NUM_REGS - 1));
`ifdef CR16_CHK_ERR_COUNT_EN
    assign stop     = last;
`else
    assign stop     = last || mismatch;
`endif

    cr16_fib_gen #(.DATA_WIDTH(DATA_WIDTH)) u_fib (
        .clk   (I_CLK),
        .rst_n (I_NRESET),
        .load  (accept),
        .step  (state == ST_COMPARE),
        .e     (exp_e)
    );

    // Scan FSM with registered outputs; select is set on entry to ISSUE and held to COMPARE.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state             <= ST_IDLE;
            idx               <= '0;
            lat_cnt           <= '0;
            phase_q           <= 1'b0;
            seen              <= 1'b0;
            bus.read_port_sel <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.pass          <= 1'b0;
            bus.fail_index    <= '0;
            bus.fail_data     <= '0;
`ifdef CR16_CHK_ERR_COUNT_EN
            bus.err_count     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state             <= ST_ISSUE;
                        idx               <= '0;
                        phase_q           <= bus.phase;
                        seen              <= 1'b0;
                        bus.read_port_sel <= '0;
                        bus.busy          <= 1'b1;
                        bus.done          <= 1'b0;
                        bus.pass          <= 1'b0;
                        bus.fail_index    <= '0;
                        bus.fail_data     <= '0;
`ifdef CR16_CHK_ERR_COUNT_EN
                        bus.err_count     <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (READ_LATENCY == 0) begin
                        state <= ST_COMPARE;
                    end else begin
                        state   <= ST_WAIT;
                        lat_cnt <= 2'(READ_LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) state <= ST_COMPARE;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                ST_COMPARE: begin
                    if (mismatch && !seen) begin
                        seen           <= 1'b1;
                        bus.fail_index <= idx;
                        bus.fail_data  <= bus.read_data;
                    end
`ifdef CR16_CHK_ERR_COUNT_EN
                    if (mismatch) bus.err_count <= err_sat_inc(bus.err_count);
`endif
                    if (stop) begin
                        state             <= ST_DONE;
                        bus.read_port_sel <= '0;
                        bus.busy          <= 1'b0;
                        bus.done          <= 1'b1;
                        bus.pass          <= !(seen || mismatch);
                    end else begin
                        state             <= ST_ISSUE;
                        idx               <= idx + 1'b1;
                        bus.read_port_sel <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_test1_checker.sv
// Scoreboard bench for cr16_test1_checker: default instance (16b, 8 regs, latency 1)
// plus a wide-scan instance (8b, 16 regs, latency 2).
module tb_cr16_test1_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

`ifdef CR16_CHK_ERR_COUNT_EN
    localparam int LAT_T2B = 24;
    localparam int ERR_T2B = 8;
    localparam int LAT_T3  = 24;
`else
    localparam int LAT_T2B = 3;
    localparam int ERR_T2B = 0;
    localparam int LAT_T3  = 18;
`endif

    typedef struct {
        logic        pass;
        logic [3:0]  fidx;
        logic [15:0] fdata;
        int          lat;
        logic [4:0]  errc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    cr16_test1_checker_if #(.DATA_WIDTH(16)) b1();
    cr16_test1_checker_if #(.DATA_WIDTH(8))  b2();

    cr16_test1_checker #(.DATA_WIDTH(16), .NUM_REGS(8), .READ_LATENCY(1)) dut1 (
        .I_CLK(clk), .I_NRESET(rst_n), .bus(b1.master));
    cr16_test1_checker #(.DATA_WIDTH(8), .NUM_REGS(16), .READ_LATENCY(2)) dut2 (
        .I_CLK(clk), .I_NRESET(rst_n), .bus(b2.master));

    // Register-file models with the configured read latency.
    logic [15:0] regs1[16];
    logic [7:0]  regs2[16];
    logic [3:0]  s1d  = '0;
    logic [3:0]  s2d1 = '0;
    logic [3:0]  s2d2 = '0;
    always @(posedge clk) begin
        s1d  <= b1.read_port_sel;
        s2d1 <= b2.read_port_sel;
        s2d2 <= s2d1;
        cyc  <= cyc + 1;
    end
    assign b1.read_data = regs1[s1d];
    assign b2.read_data = regs2[s2d2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [3:0] fi, input logic [15:0] fd,
                                input int lat, input logic [4:0] ec);
        exp_t e;
        e.pass = p; e.fidx = fi; e.fdata = fd; e.lat = lat; e.errc = ec;
        return e;
    endfunction

    // Monitor for dut1: latency measured from first BUSY cycle to DONE rising.
    initial begin : mon1
        logic bp, dp;
        int   st;
        exp_t e;
        bp = 1'b0; dp = 1'b0; st = 0;
        forever begin
            @(negedge clk);
            if (b1.busy && !bp) st = cyc;
            if (b1.done && !dp) begin
                if (q1.size() == 0) check("dut1 unexpected done", {31'd0, b1.done}, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("dut1 pass", {31'd0, b1.pass}, {31'd0, e.pass});
                    check("dut1 fail_index", {28'd0, b1.fail_index}, {28'd0, e.fidx});
                    check("dut1 fail_data", {16'd0, b1.fail_data}, {16'd0, e.fdata});
                    check("dut1 done latency", cyc - st, e.lat);
`ifdef CR16_CHK_ERR_COUNT_EN
                    check("dut1 err_count", {27'd0, b1.err_count}, {27'd0, e.errc});
`endif
                end
            end
            bp = b1.busy; dp = b1.done;
        end
    end

    initial begin : mon2
        logic bp, dp;
        int   st;
        exp_t e;
        bp = 1'b0; dp = 1'b0; st = 0;
        forever begin
            @(negedge clk);
            if (b2.busy && !bp) st = cyc;
            if (b2.done && !dp) begin
                if (q2.size() == 0) check("dut2 unexpected done", {31'd0, b2.done}, 32'd0);
                else begin
                    e = q2.pop_front();
                    check("dut2 pass", {31'd0, b2.pass}, {31'd0, e.pass});
                    check("dut2 fail_index", {28'd0, b2.fail_index}, {28'd0, e.fidx});
                    check("dut2 fail_data", {24'd0, b2.fail_data}, {16'd0, e.fdata});
                    check("dut2 done latency", cyc - st, e.lat);
`ifdef CR16_CHK_ERR_COUNT_EN
                    check("dut2 err_count", {27'd0, b2.err_count}, {27'd0, e.errc});
`endif
                end
            end
            bp = b2.busy; dp = b2.done;
        end
    end

    task automatic wait_done1();
        int n = 0;
        while (!b1.done && n < 200) begin @(negedge clk); n++; end
        if (!b1.done) begin check("dut1 done timeout", {31'd0, b1.done}, 32'd1); q1.delete(); end
    endtask

    task automatic wait_done2();
        int n = 0;
        while (!b2.done && n < 300) begin @(negedge clk); n++; end
        if (!b2.done) begin check("dut2 done timeout", {31'd0, b2.done}, 32'd1); q2.delete(); end
    endtask

    task automatic run1(input logic ph, input exp_t e);
        @(negedge clk); b1.start = 1'b1; b1.phase = ph; q1.push_back(e);
        @(negedge clk); b1.start = 1'b0;
        wait_done1();
    endtask

    task automatic run2(input logic ph, input exp_t e);
        @(negedge clk); b2.start = 1'b1; b2.phase = ph; q2.push_back(e);
        @(negedge clk); b2.start = 1'b0;
        wait_done2();
    endtask

    task automatic load1(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7);
        regs1[0] = v0; regs1[1] = v1; regs1[2] = v2; regs1[3] = v3;
        regs1[4] = v4; regs1[5] = v5; regs1[6] = v6; regs1[7] = v7;
    endtask

    task automatic check_zero1(input string tag);
        check({tag, " sel"},        {28'd0, b1.read_port_sel}, 32'd0);
        check({tag, " busy"},       {31'd0, b1.busy},          32'd0);
        check({tag, " done"},       {31'd0, b1.done},          32'd0);
        check({tag, " pass"},       {31'd0, b1.pass},          32'd0);
        check({tag, " fail_index"}, {28'd0, b1.fail_index},    32'd0);
        check({tag, " fail_data"},  {16'd0, b1.fail_data},     32'd0);
    endtask

    logic [7:0] fib8[16];

    initial begin
        for (int i = 0; i < 16; i++) begin regs1[i] = '0; regs2[i] = '0; end
        b1.start = 1'b0; b1.phase = 1'b0;
        b2.start = 1'b0; b2.phase = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero1("reset");
        check("reset dut2 done", {31'd0, b2.done}, 32'd0);
        rst_n = 1'b1;

        // 1: clean fibonacci scan
        load1(1, 1, 2, 3, 5, 8, 13, 21);
        run1(1'b0, mk(1'b1, 4'd0, 16'd0, 24, 5'd0));

        // 2: fibonacci+1 data, phase 1 passes, phase 0 fails at r0
        load1(2, 2, 3, 4, 6, 9, 14, 22);
        run1(1'b1, mk(1'b1, 4'd0, 16'd0, 24, 5'd0));
        run1(1'b0, mk(1'b0, 4'd0, 16'd2, LAT_T2B, 5'(ERR_T2B)));

        // 3: single corrupted register r5
        load1(1, 1, 2, 3, 5, 7, 13, 21);
        run1(1'b0, mk(1'b0, 4'd5, 16'd7, LAT_T3, 5'd1));

        // 4: async reset mid-scan, then a clean rescan
        load1(1, 1, 2, 3, 5, 8, 13, 21);
        @(negedge clk); b1.start = 1'b1; b1.phase = 1'b0; q1.push_back(mk(1'b1, 4'd0, 16'd0, 24, 5'd0));
        @(negedge clk); b1.start = 1'b0;
        begin
            int n = 0;
            while (b1.read_port_sel != 4'd3 && n < 50) begin @(negedge clk); n++; end
        end
        check("sel reached 3 before reset", {28'd0, b1.read_port_sel}, 32'd3);
        #2 rst_n = 1'b0;
        #1 check_zero1("midscan reset");
        q1.delete();
        @(negedge clk); rst_n = 1'b1;
        run1(1'b0, mk(1'b1, 4'd0, 16'd0, 24, 5'd0));

        // 5: START pulses mid-scan are ignored; START in DONE restarts
        @(negedge clk); b1.start = 1'b1; q1.push_back(mk(1'b1, 4'd0, 16'd0, 24, 5'd0));
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            b1.start = (i == 5 || i == 12);
        end
        check("done held after scan", {31'd0, b1.done}, 32'd1);
        b1.start = 1'b1; q1.push_back(mk(1'b1, 4'd0, 16'd0, 24, 5'd0));
        @(negedge clk); b1.start = 1'b0;
        check("restart clears done", {31'd0, b1.done}, 32'd0);
        check("restart sets busy", {31'd0, b1.busy}, 32'd1);
        wait_done1();

        // 6: 8-bit, 16 registers, latency 2, fibonacci mod 256
        fib8[0] = 8'd1; fib8[1] = 8'd1;
        for (int i = 2; i < 16; i++) fib8[i] = fib8[i-1] + fib8[i-2];
        for (int i = 0; i < 16; i++) regs2[i] = fib8[i];
        check("fib8 r13", {24'd0, regs2[13]}, 32'd121);
        check("fib8 r15", {24'd0, regs2[15]}, 32'd219);
        run2(1'b0, mk(1'b1, 4'd0, 16'd0, 64, 5'd0));
        regs2[15] = 8'd0;
        run2(1'b0, mk(1'b0, 4'd15, 16'd0, 64, 5'd1));

        repeat (3) @(negedge clk);
        check("dut1 scoreboard drained", q1.size(), 32'd0);
        check("dut2 scoreboard drained", q2.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
